// File: rtl/fir_pkg.sv
// fir_pkg: op encodings and widths shared by the FIR datapath
package fir_pkg;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;
endpackage

// File: rtl/fir_regfile.sv
// fir_regfile: NUM_REGS x DATA_W storage, two async reads, OUT_REG tap, one sync write
module fir_regfile
    import fir_pkg::*;
#(
    parameter int DW       = DATA_W,
    parameter int NUM_REGS = 16,
    parameter int OUT_REG  = 0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             we,
    input  logic [IDX_W-1:0] wa,
    input  logic [DW-1:0]    wd,
    input  logic [IDX_W-1:0] ra,
    input  logic [IDX_W-1:0] rb,
    output logic [DW-1:0]    rdata_a,
    output logic [DW-1:0]    rdata_b,
    output logic [DW-1:0]    out_data
);
    logic [DW-1:0] regs [NUM_REGS];

    // indices beyond the array read as zero and never write
    assign rdata_a  = (int'(ra) < NUM_REGS) ? regs[ra] : '0;
    assign rdata_b  = (int'(rb) < NUM_REGS) ? regs[rb] : '0;
    assign out_data = regs[OUT_REG];

    always_ff @(posedge clk) begin
        if (!nReset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && int'(wa) < NUM_REGS) begin
            regs[wa] <= wd;
        end
    end
endmodule

// File: rtl/fir_datapath.sv
// fir_datapath: op decode, add/sub with signed overflow flag, V and busy flops
// Optional clamping of overflowed results when FIR_DATAPATH_SATURATE_EN is defined.
module fir_datapath
    import fir_pkg::*;
#(
    parameter int DW       = DATA_W,
    parameter int NUM_REGS = 16,
    parameter int OUT_REG  = 0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [1:0]       op,
    input  logic [IDX_W-1:0] A,
    input  logic [IDX_W-1:0] B,
    input  logic [IDX_W-1:0] C,
    input  logic [DW-1:0]    data_in,
    output logic             V,
    output logic [DW-1:0]    outreg_data,
    output logic             busy
);
    logic [DW-1:0] a, b, sum, res, wd;
    logic          sub, arith, ovf;

    fir_regfile #(.DW(DW), .NUM_REGS(NUM_REGS), .OUT_REG(OUT_REG)) u_rf (
        .clk(clk),
        .nReset(nReset),
        .we(op != OP_NOP),
        .wa(C),
        .wd(wd),
        .ra(A),
        .rb(B),
        .rdata_a(a),
        .rdata_b(b),
        .out_data(outreg_data)
    );

    assign arith = op[1];
    assign sub   = (op == OP_SUB);
    assign sum   = sub ? a - b : a + b;
    // on overflow the true result always carries the sign of operand a
    assign ovf   = (sub ? (a[DW-1] != b[DW-1]) : (a[DW-1] == b[DW-1])) && (sum[DW-1] != a[DW-1]);
`ifdef FIR_DATAPATH_SATURATE_EN
    assign res   = ovf ? (a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : sum;
`else
    assign res   = sum;
`endif
    assign wd    = arith ? res : data_in;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            V    <= 1'b0;
            busy <= 1'b0;
        end else begin
            V    <= arith ? ovf : V;
            busy <= (op != OP_NOP);
        end
    end
endmodule
